// File: rtl/mem_wb_stage.sv
// Memory-to-writeback pipeline register with stall, bubble, sticky halt and write-enable generation.
// Optional performance counters are built when MEM_WB_PERF_EN is defined.
module mem_wb_stage #(
   parameter int WORD_W = 32,
   parameter int REG_W = 8,
   parameter logic [REG_W-1:0] RNONE = 8'h0F
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_stall,
   input  logic              mem_bubble,
   input  logic [REG_W-1:0]  mem_icode,
   input  logic [2:0]        mem_stat,
   input  logic [WORD_W-1:0] mem_valE,
   input  logic [WORD_W-1:0] mem_valM,
   input  logic [REG_W-1:0]  mem_dstE,
   input  logic [REG_W-1:0]  mem_dstM,
   output logic [REG_W-1:0]  wb_icode,
   output logic [2:0]        wb_stat,
   output logic [WORD_W-1:0] wb_valE,
   output logic [WORD_W-1:0] wb_valM,
   output logic [REG_W-1:0]  wb_dstE,
   output logic [REG_W-1:0]  wb_dstM,
   output logic              wb_weE,
   output logic              wb_weM,
   output logic              cpu_halted
`ifdef MEM_WB_PERF_EN
   ,
   output logic [31:0]       perf_retired,
   output logic [31:0]       perf_bubbles
`endif
);

   localparam logic [REG_W-1:0] ICODE_NOP = REG_W'(1);
   localparam logic [2:0]       STAT_BUB  = 3'd0;
   localparam logic [2:0]       STAT_AOK  = 3'd1;
   localparam logic [2:0]       STAT_HLT  = 3'd2;

   // Control has no handshake: stall and bubble are level-sensitive commands
   // sampled on each rising edge; bubble wins over stall, halt wins over both.
   logic bubble_en;
   logic load_en;
   logic fault_in;

   always_comb begin
      bubble_en = !cpu_halted && mem_bubble;
      load_en   = !cpu_halted && !mem_bubble && !mem_stall;
      // Everything from HLT upward (including undefined 5-7) stops the pipe.
      fault_in  = (mem_stat >= STAT_HLT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_icode   <= ICODE_NOP;
         wb_stat    <= STAT_BUB;
         wb_valE    <= '0;
         wb_valM    <= '0;
         wb_dstE    <= RNONE;
         wb_dstM    <= RNONE;
         cpu_halted <= 1'b0;
      end else if (bubble_en) begin
         wb_icode   <= ICODE_NOP;
         wb_stat    <= STAT_BUB;
         wb_valE    <= '0;
         wb_valM    <= '0;
         wb_dstE    <= RNONE;
         wb_dstM    <= RNONE;
      end else if (load_en) begin
         wb_icode   <= mem_icode;
         wb_stat    <= mem_stat;
         wb_valE    <= mem_valE;
         wb_valM    <= mem_valM;
         wb_dstE    <= mem_dstE;
         wb_dstM    <= mem_dstM;
         cpu_halted <= fault_in;
      end
   end

   // Enables come only from the W registers so a faulting status can never write.
   always_comb begin
      wb_weE = (wb_stat == STAT_AOK) && (wb_dstE != RNONE);
      wb_weM = (wb_stat == STAT_AOK) && (wb_dstM != RNONE);
   end

`ifdef MEM_WB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_retired <= '0;
         perf_bubbles <= '0;
      end else begin
         if (load_en && (mem_stat == STAT_AOK) && (perf_retired != 32'hFFFF_FFFF))
            perf_retired <= perf_retired + 32'd1;
         if (bubble_en && (perf_bubbles != 32'hFFFF_FFFF))
            perf_bubbles <= perf_bubbles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed scoreboard bench for mem_wb_stage: expected W values queued at drive, checked after the edge.
module tb_mem_wb_stage;

   localparam int EW = 94;

   logic        clk;
   logic        rst;
   logic        mem_stall;
   logic        mem_bubble;
   logic [7:0]  mem_icode;
   logic [2:0]  mem_stat;
   logic [31:0] mem_valE;
   logic [31:0] mem_valM;
   logic [7:0]  mem_dstE;
   logic [7:0]  mem_dstM;
   logic [7:0]  wb_icode;
   logic [2:0]  wb_stat;
   logic [31:0] wb_valE;
   logic [31:0] wb_valM;
   logic [7:0]  wb_dstE;
   logic [7:0]  wb_dstM;
   logic        wb_weE;
   logic        wb_weM;
   logic        cpu_halted;
`ifdef MEM_WB_PERF_EN
   logic [31:0] perf_retired;
   logic [31:0] perf_bubbles;
   logic [63:0] perf_q[$];
   logic [31:0] m_pr;
   logic [31:0] m_pb;
`endif

   int errors = 0;
   int checks = 0;
   logic [EW-1:0] exp_q[$];

   logic [7:0]  m_icode;
   logic [2:0]  m_stat;
   logic [31:0] m_vale;
   logic [31:0] m_valm;
   logic [7:0]  m_dste;
   logic [7:0]  m_dstm;
   logic        m_halt;

   mem_wb_stage dut (
      .clk(clk), .rst(rst), .mem_stall(mem_stall), .mem_bubble(mem_bubble),
      .mem_icode(mem_icode), .mem_stat(mem_stat), .mem_valE(mem_valE), .mem_valM(mem_valM),
      .mem_dstE(mem_dstE), .mem_dstM(mem_dstM),
      .wb_icode(wb_icode), .wb_stat(wb_stat), .wb_valE(wb_valE), .wb_valM(wb_valM),
      .wb_dstE(wb_dstE), .wb_dstM(wb_dstM), .wb_weE(wb_weE), .wb_weM(wb_weM),
      .cpu_halted(cpu_halted)
`ifdef MEM_WB_PERF_EN
      , .perf_retired(perf_retired), .perf_bubbles(perf_bubbles)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [EW-1:0] model_vec();
      logic we_e;
      logic we_m;
      we_e = (m_stat == 3'd1) && (m_dste != 8'h0F);
      we_m = (m_stat == 3'd1) && (m_dstm != 8'h0F);
      return {m_icode, m_stat, m_vale, m_valm, m_dste, m_dstm, we_e, we_m, m_halt};
   endfunction

   task automatic model_bubble();
      m_icode = 8'h01; m_stat = 3'd0; m_vale = '0; m_valm = '0;
      m_dste = 8'h0F; m_dstm = 8'h0F;
   endtask

   task automatic check(input string tag);
      logic [EW-1:0] obs;
      logic [EW-1:0] e;
      obs = {wb_icode, wb_stat, wb_valE, wb_valM, wb_dstE, wb_dstM, wb_weE, wb_weM, cpu_halted};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: observed=%h expected=<empty queue>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
         end
      end
`ifdef MEM_WB_PERF_EN
      begin
         logic [63:0] pe;
         checks++;
         pe = perf_q.pop_front();
         assert ({perf_retired, perf_bubbles} === pe) else begin
            errors++;
            $error("FAIL %s_perf: observed=%h expected=%h", tag, {perf_retired, perf_bubbles}, pe);
         end
      end
`endif
   endtask

   // driver: one edge with given controls and M-stage values, model updated alongside
   task automatic step(input logic r, input logic s, input logic b, input logic [7:0] ic,
                       input logic [2:0] st, input logic [31:0] ve, input logic [31:0] vm,
                       input logic [7:0] de, input logic [7:0] dm, input string tag);
      @(negedge clk);
      rst = r; mem_stall = s; mem_bubble = b; mem_icode = ic; mem_stat = st;
      mem_valE = ve; mem_valM = vm; mem_dstE = de; mem_dstM = dm;
      if (r) begin
         model_bubble();
         m_halt = 1'b0;
`ifdef MEM_WB_PERF_EN
         m_pr = '0; m_pb = '0;
`endif
      end else if (!m_halt) begin
         if (b) begin
            model_bubble();
`ifdef MEM_WB_PERF_EN
            if (m_pb != 32'hFFFF_FFFF) m_pb = m_pb + 1;
`endif
         end else if (!s) begin
            m_icode = ic; m_stat = st; m_vale = ve; m_valm = vm; m_dste = de; m_dstm = dm;
            m_halt = (st == 3'd2) || (st == 3'd3) || (st == 3'd4) || (st > 3'd4);
`ifdef MEM_WB_PERF_EN
            if (st == 3'd1 && m_pr != 32'hFFFF_FFFF) m_pr = m_pr + 1;
`endif
         end
      end
      exp_q.push_back(model_vec());
`ifdef MEM_WB_PERF_EN
      perf_q.push_back({m_pr, m_pb});
`endif
      @(posedge clk);
      #1;
      check(tag);
   endtask

   initial begin
      rst = 1'b1; mem_stall = 1'b0; mem_bubble = 1'b0; mem_icode = '0; mem_stat = '0;
      mem_valE = '0; mem_valM = '0; mem_dstE = '0; mem_dstM = '0;
      m_icode = '0; m_stat = '0; m_vale = '0; m_valm = '0; m_dste = '0; m_dstm = '0; m_halt = 1'b0;
`ifdef MEM_WB_PERF_EN
      m_pr = '0; m_pb = '0;
`endif

      step(1, 0, 0, 8'h00, 3'd0, 32'h0, 32'h0, 8'h00, 8'h00, "reset");
      step(0, 0, 0, 8'h06, 3'd1, 32'h0000_00AA, 32'h0, 8'h03, 8'h0F, "load_aa");
      step(0, 0, 0, 8'h05, 3'd1, 32'h1111_1111, 32'h2222_2222, 8'h02, 8'h04, "load_a");
      for (int i = 0; i < 3; i++)
         step(0, 1, 0, 8'h07, 3'd1, 32'hDEAD_0000 + i, 32'hBEEF_0000 + i, 8'h01, 8'h05, "stall_hold");
      step(0, 1, 1, 8'h07, 3'd1, 32'h5555_5555, 32'h6666_6666, 8'h01, 8'h05, "stall_bubble");
      step(0, 0, 1, 8'h07, 3'd1, 32'h7777_7777, 32'h8888_8888, 8'h01, 8'h05, "bubble");
      step(0, 0, 0, 8'h03, 3'd1, 32'h0, 32'hCAFE_F00D, 8'h0F, 8'h07, "load_dstm_only");

      for (int i = 0; i < 8; i++)
         step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
              3'($urandom_range(0, 1)), $urandom, $urandom, 8'($urandom_range(0, 15)),
              8'($urandom_range(0, 15)), "rand_load");

      step(0, 0, 0, 8'h00, 3'd2, 32'h0000_0123, 32'h0000_0456, 8'h02, 8'h03, "halt_entry");
      for (int i = 0; i < 4; i++)
         step(0, 0, 0, 8'h06, 3'd1, 32'hAAAA_0000 + i, 32'hBBBB_0000 + i, 8'h01, 8'h02, "halt_freeze");
      step(0, 1, 1, 8'h06, 3'd1, 32'h1, 32'h2, 8'h01, 8'h02, "halt_freeze_bubble");
      step(1, 1, 1, 8'h06, 3'd1, 32'h1, 32'h2, 8'h01, 8'h02, "reset_mid_halt");
      step(0, 0, 0, 8'h06, 3'd1, 32'h0000_0BCD, 32'h0, 8'h04, 8'h0F, "load_after_reset");

      step(0, 0, 0, 8'h05, 3'd3, 32'h9, 32'h9, 8'h01, 8'h01, "adr_halt");
      step(0, 0, 0, 8'h05, 3'd1, 32'hA, 32'hA, 8'h01, 8'h01, "adr_freeze");
      step(1, 0, 0, 8'h05, 3'd1, 32'h0, 32'h0, 8'h01, 8'h01, "reset2");
      step(0, 0, 0, 8'h0C, 3'd6, 32'h3, 32'h4, 8'h05, 8'h06, "stat6_halt");
      step(0, 0, 1, 8'h0C, 3'd1, 32'h3, 32'h4, 8'h05, 8'h06, "stat6_freeze");
      step(1, 0, 0, 8'h00, 3'd0, 32'h0, 32'h0, 8'h00, 8'h00, "reset3");
      step(0, 0, 0, 8'h0D, 3'd4, 32'h3, 32'h4, 8'h05, 8'h06, "ins_halt");
      step(1, 0, 0, 8'h00, 3'd0, 32'h0, 32'h0, 8'h00, 8'h00, "reset4");

`ifdef MEM_WB_PERF_EN
      @(negedge clk);
      force dut.perf_retired = 32'hFFFF_FFFE;
      #1;
      release dut.perf_retired;
      m_pr = 32'hFFFF_FFFE;
      step(0, 0, 0, 8'h06, 3'd1, 32'h1, 32'h1, 8'h01, 8'h02, "sat_first");
      step(0, 0, 0, 8'h06, 3'd1, 32'h2, 32'h2, 8'h01, 8'h02, "sat_hold");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter: WORD_W, 32, width of valE/valM data words.
REQ-002 Parameter: REG_W, 8, width of dstE/dstM register identifiers and icode.
REQ-003 Parameter: RNONE, 8'h0F, register ID meaning "no destination".
REQ-004 Port: clk  input  1  single rising-edge clock.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: mem_stall  input  1  hold W register contents this cycle.
REQ-007 Port: mem_bubble  input  1  load a bubble (NOP) instead of M-stage values.
REQ-008 Port: mem_icode  input  REG_W  instruction code from M stage.
REQ-009 Port: mem_stat  input  3  status (0 BUB, 1 AOK, 2 HLT, 3 ADR, 4 INS).
REQ-010 Port: mem_valE, mem_valM  input  WORD_W each  ALU result, memory read data.
REQ-011 Port: mem_dstE, mem_dstM  input  REG_W each  destination register IDs.
REQ-012 Port: wb_icode, wb_stat, wb_valE, wb_valM, wb_dstE, wb_dstM  output  widths as the matching inputs  registered W-stage values.
REQ-013 Port: wb_weE, wb_weM  output  1 each  register-file write enables.
REQ-014 Port: cpu_halted  output  1  sticky halt indicator.

Function
REQ-015 All W-stage outputs except the write enables SHALL be registered on the rising clk edge; latency from M inputs to W outputs is 1 cycle.
REQ-016 Per-edge priority: rst > halted-freeze > mem_bubble > mem_stall > load.
REQ-017 Load: each W register takes the corresponding mem_* value.
REQ-018 Bubble: wb_icode=8'h01 (NOP), wb_stat=0 (BUB), wb_dstE=wb_dstM=RNONE, wb_valE=wb_valM=0.
REQ-019 Stall without bubble: all W registers hold their current values.
REQ-020 mem_stall and mem_bubble both high: bubble applied (REQ-018).
REQ-021 cpu_halted SHALL set on the edge that loads mem_stat in {2,3,4}; it is visible in the same cycle the faulting status appears on wb_stat.
REQ-022 While cpu_halted=1, all W registers hold (freeze) regardless of stall/bubble/M inputs, until rst.
REQ-023 wb_weE = (wb_stat==1) AND (wb_dstE != RNONE); wb_weM = (wb_stat==1) AND (wb_dstM != RNONE); combinational from W registers only.
REQ-024 Instructions with wb_stat of HLT, ADR, INS or BUB SHALL never assert a write enable.
REQ-025 mem_stat values 5-7 SHALL be treated as INS for halting purposes and loaded unchanged.

Reset
REQ-026 On a clk edge with rst=1: wb_icode=8'h01, wb_stat=0, wb_valE=wb_valM=0, wb_dstE=wb_dstM=RNONE, cpu_halted=0; wb_weE=wb_weM=0 as a consequence.
REQ-027 rst SHALL override an in-progress halt, stall, or bubble on that same edge; normal loading resumes the following edge.

Configuration
REQ-028 Macro MEM_WB_PERF_EN: when defined, outputs perf_retired[31:0] and perf_bubbles[31:0] exist.
REQ-029 perf_retired increments on each edge that loads (REQ-017) with mem_stat==1; perf_bubbles increments on each edge applying REQ-018; both frozen while halted, saturate at 32'hFFFFFFFF, reset to 0.
REQ-030 Without MEM_WB_PERF_EN the counters and their ports SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Load: mem_stat=1, mem_dstE=8'h03, mem_valE=32'h0000_00AA, one edge -> wb_valE=32'h0000_00AA, wb_dstE=8'h03, wb_weE=1.
REQ-032 Stall: load value A, then mem_stall=1 for 3 cycles with new M values -> W outputs stay A all 3 cycles.
REQ-033 Stall+bubble same cycle -> wb_icode=8'h01, wb_stat=0, both dst=8'h0F, wb_weE=wb_weM=0; perf_bubbles +1 when enabled.
REQ-034 Halt: load mem_stat=2, then 4 AOK loads -> cpu_halted=1 from first edge, W outputs frozen on HLT entry, write enables 0, perf_retired unchanged.
REQ-035 Reset mid-halt: assert rst one edge -> all REQ-026 values, cpu_halted=0; next AOK load passes normally.
REQ-036 Saturation (MEM_WB_PERF_EN, counter forced to 32'hFFFFFFFE): two AOK loads -> perf_retired=32'hFFFFFFFF, no wrap to 0.
